updown_bounce_counter: RTL and testbench

- Parametrised successor to the team's 8-bit bounded up/down cycle counter.
- Adds generic count width, a selectable bounce/wrap mode, a programmable initial direction, an abort command and a status register.
- Replaces the shared inout data bus with separate write and read buses.
- Sits behind the control-register interface and drives cout/dir/ec/err to downstream timing logic.

---
 rtl/updown_bounce_counter_if.sv | 14 +
 rtl/updown_bounce_counter.sv | 198 +++++++++++++++++++
 tb/tb_updown_bounce_counter.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/updown_bounce_counter_if.sv
// Register-access bus for updown_bounce_counter: write strobe/data, read strobe
// and the registered read data returned by the counter.
interface updown_bounce_counter_if #(
  parameter int DW = 8
);
  logic          wr_en;
  logic          rd_en;
  logic [2:0]    addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  modport master (output wr_en, rd_en, addr, wdata, input rdata);
  modport slave  (input wr_en, rd_en, addr, wdata, output rdata);
endinterface

// File: rtl/updown_bounce_counter.sv
// Parametrised bounded up/down counter with bounce or wrap traversal between
// LLR and ULR, repeated CCR times from PLR, behind a small register file.
module updown_bounce_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  updown_bounce_counter_if.slave  bus,
  input  logic                    start,
  output logic [WIDTH-1:0]        cout,
  output logic                    dir,
  output logic                    busy,
  output logic                    ec,
  output logic                    err
);

  localparam int DW = (WIDTH > CNT_W) ? WIDTH : CNT_W;
  localparam int PW = WIDTH + 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_e;

  state_e             stateQ, stateD;
  logic [WIDTH-1:0]   plrQ, plrD;
  logic [WIDTH-1:0]   ulrQ, ulrD;
  logic [WIDTH-1:0]   llrQ, llrD;
  logic [CNT_W-1:0]   ccrQ, ccrD;
  logic               modeQ, modeD;
  logic               dirInitQ, dirInitD;
  logic [WIDTH-1:0]   coutQ, coutD;
  logic               dirQ, dirD;
  logic               ecQ, ecD;
  logic               errQ, errD;
  logic [CNT_W-1:0]   remQ, remD;
  logic [PW-1:0]      stepQ, stepD;
  logic [DW-1:0]      rdataQ, rdataD;

  logic               running;
  logic               cfgWr;
  logic               abortWr;
  logic               cfgOk;
  logic [WIDTH:0]     spanW;
  logic               spanZero;
  logic [PW-1:0]      periodM1;

  assign running  = (stateQ == RUN);
  assign cfgWr    = bus.wr_en && !running;
  assign abortWr  = bus.wr_en && (bus.addr == 3'd4) && bus.wdata[2];
  assign cfgOk    = (llrQ <= plrQ) && (plrQ <= ulrQ) && (ccrQ != '0);
  assign spanW    = {1'b0, ulrQ} - {1'b0, llrQ};
  assign spanZero = (spanW == '0);

  // Last step index of one period: bounce covers 2*span steps, wrap span+1.
  always_comb begin
    periodM1 = '0;
    if (!spanZero) begin
      if (modeQ) periodM1 = {1'b0, spanW};
      else       periodM1 = {spanW, 1'b0} - 1'b1;
    end
  end

  always_comb begin
    stateD   = stateQ;
    plrD     = plrQ;
    ulrD     = ulrQ;
    llrD     = llrQ;
    ccrD     = ccrQ;
    modeD    = modeQ;
    dirInitD = dirInitQ;
    coutD    = coutQ;
    dirD     = dirQ;
    ecD      = ecQ;
    errD     = errQ;
    remD     = remQ;
    stepD    = stepQ;
    rdataD   = rdataQ;

    if (cfgWr) begin
      case (bus.addr)
        3'd0: plrD = bus.wdata[WIDTH-1:0];
        3'd1: ulrD = bus.wdata[WIDTH-1:0];
        3'd2: llrD = bus.wdata[WIDTH-1:0];
        3'd3: ccrD = bus.wdata[CNT_W-1:0];
        3'd4: begin
          modeD    = bus.wdata[0];
          dirInitD = bus.wdata[1];
        end
        default: ;
      endcase
    end

    if (bus.rd_en) begin
      case (bus.addr)
        3'd0:    rdataD = DW'(plrQ);
        3'd1:    rdataD = DW'(ulrQ);
        3'd2:    rdataD = DW'(llrQ);
        3'd3:    rdataD = DW'(ccrQ);
        3'd4:    rdataD = DW'({dirInitQ, modeQ});
        3'd5:    rdataD = DW'({errQ, ecQ, dirQ, running});
        default: rdataD = '0;
      endcase
    end

    case (stateQ)
      RUN: begin
        if (abortWr) begin
          stateD = IDLE;
          ecD    = 1'b0;
        end else begin
          if (!spanZero) begin
            if (modeQ) begin
              if (dirQ) coutD = (coutQ == ulrQ) ? llrQ : coutQ + 1'b1;
              else      coutD = (coutQ == llrQ) ? ulrQ : coutQ - 1'b1;
            end else if (dirQ && (coutQ == ulrQ)) begin
              dirD  = 1'b0;
              coutD = ulrQ - 1'b1;
            end else if (!dirQ && (coutQ == llrQ)) begin
              dirD  = 1'b1;
              coutD = llrQ + 1'b1;
            end else begin
              coutD = dirQ ? coutQ + 1'b1 : coutQ - 1'b1;
            end
          end
          // A full period lands back on PLR, so completion needs no cout fix-up.
          if (stepQ == periodM1) begin
            stepD = '0;
            remD  = remQ - 1'b1;
            if (remQ == CNT_W'(1)) begin
              stateD = DONE;
              ecD    = 1'b1;
            end
          end else begin
            stepD = stepQ + 1'b1;
          end
        end
      end
      default: begin
        if (start) begin
          ecD = 1'b0;
          if (cfgOk) begin
            stateD = RUN;
            coutD  = plrQ;
            dirD   = dirInitQ;
            remD   = ccrQ;
            stepD  = '0;
            errD   = 1'b0;
          end else begin
            stateD = ERR;
            coutD  = '0;
            errD   = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ   <= IDLE;
      plrQ     <= '0;
      ulrQ     <= '1;
      llrQ     <= '0;
      ccrQ     <= '0;
      modeQ    <= 1'b0;
      dirInitQ <= 1'b0;
      coutQ    <= '0;
      dirQ     <= 1'b0;
      ecQ      <= 1'b0;
      errQ     <= 1'b0;
      remQ     <= '0;
      stepQ    <= '0;
      rdataQ   <= '0;
    end else begin
      stateQ   <= stateD;
      plrQ     <= plrD;
      ulrQ     <= ulrD;
      llrQ     <= llrD;
      ccrQ     <= ccrD;
      modeQ    <= modeD;
      dirInitQ <= dirInitD;
      coutQ    <= coutD;
      dirQ     <= dirD;
      ecQ      <= ecD;
      errQ     <= errD;
      remQ     <= remD;
      stepQ    <= stepD;
      rdataQ   <= rdataD;
    end
  end

  assign cout      = coutQ;
  assign dir       = dirQ;
  assign busy      = running;
  assign ec        = ecQ;
  assign err       = errQ;
  assign bus.rdata = rdataQ;

endmodule

// File: tb/tb_updown_bounce_counter.sv
// Scoreboard bench for updown_bounce_counter: expected cout/busy/ec and read
// data are queued as stimulus is driven and popped as the DUT produces them.
module tb_updown_bounce_counter;

  typedef struct packed {
    logic [7:0] cout;
    logic       busy;
    logic       ec;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] cout;
  logic       dir;
  logic       busy;
  logic       ec;
  logic       err;

  int passCount  = 0;
  int totalCount = 0;

  exp_t       expQ[$];
  logic [7:0] rdQ[$];

  updown_bounce_counter_if #(.DW(8)) bus ();

  updown_bounce_counter #(.WIDTH(8), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .start (start),
    .cout  (cout),
    .dir   (dir),
    .busy  (busy),
    .ec    (ec),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] c, input logic b, input logic e);
    exp_t x;
    x.cout = c;
    x.busy = b;
    x.ec   = e;
    expQ.push_back(x);
  endtask

  task automatic test_reset();
    logic [7:0] want;
    logic [7:0] resetVals [8];
    resetVals = '{8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    totalCount++;
    if ({cout, dir, busy, ec, err, bus.rdata} !== {8'd0, 4'b0000, 8'd0}) begin
      $display("[TB] FAIL reset_outputs: got cout=%0d dir=%0b busy=%0b ec=%0b err=%0b rdata=%0d, want all 0",
               cout, dir, busy, ec, err, bus.rdata);
    end else passCount++;
    // Back-to-back reads across all eight addresses.
    for (int i = 0; i < 8; i++) begin
      bus.rd_en = 1'b1;
      bus.addr  = 3'(i);
      rdQ.push_back(resetVals[i]);
      tick();
      want = rdQ.pop_front();
      totalCount++;
      if (bus.rdata !== want) begin
        $display("[TB] FAIL reset_read_addr%0d: got %0d, want %0d", i, bus.rdata, want);
      end else passCount++;
    end
    bus.rd_en = 1'b1;
    bus.addr  = 3'd1;
    tick();
    bus.rd_en = 1'b0;
    bus.addr  = 3'd0;
    tick();
    totalCount++;
    if (bus.rdata !== 8'd255) begin
      $display("[TB] FAIL read_hold: got %0d, want 255", bus.rdata);
    end else passCount++;
  endtask

  task automatic test_bounce();
    exp_t e;
    int   bseq [8];
    bseq = '{6, 7, 6, 5, 4, 3, 4, 5};
    wr_reg(3'd0, 8'd5);
    wr_reg(3'd2, 8'd3);
    wr_reg(3'd1, 8'd7);
    wr_reg(3'd3, 8'd2);
    wr_reg(3'd4, 8'd2);
    push_exp(8'd5, 1'b1, 1'b0);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 8; i++)
        push_exp(8'(bseq[i]), !(r == 1 && i == 7), (r == 1 && i == 7));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; expQ.size() != 0; n++) begin
      e = expQ.pop_front();
      totalCount++;
      if ({cout, busy, ec} !== e) begin
        $display("[TB] FAIL bounce_step%0d: got cout=%0d busy=%0b ec=%0b, want cout=%0d busy=%0b ec=%0b",
                 n, cout, busy, ec, e.cout, e.busy, e.ec);
      end else passCount++;
      if (expQ.size() != 0) tick();
    end
    totalCount++;
    if (dir !== 1'b1) begin
      $display("[TB] FAIL bounce_end_dir: got %0b, want 1", dir);
    end else passCount++;
    tick();
    totalCount++;
    if ({cout, busy, ec} !== {8'd5, 1'b0, 1'b1}) begin
      $display("[TB] FAIL bounce_done_hold: got cout=%0d busy=%0b ec=%0b, want cout=5 busy=0 ec=1",
               cout, busy, ec);
    end else passCount++;
  endtask

  task automatic test_wrap();
    exp_t e;
    int   upSeq [4];
    int   dnSeq [4];
    upSeq = '{3, 0, 1, 2};
    dnSeq = '{1, 0, 3, 2};
    wr_reg(3'd0, 8'd2);
    wr_reg(3'd2, 8'd0);
    wr_reg(3'd1, 8'd3);
    wr_reg(3'd3, 8'd1);
    for (int d = 1; d >= 0; d--) begin
      wr_reg(3'd4, (d == 1) ? 8'd3 : 8'd1);
      push_exp(8'd2, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++)
        push_exp(8'((d == 1) ? upSeq[i] : dnSeq[i]), i != 3, i == 3);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; expQ.size() != 0; n++) begin
        e = expQ.pop_front();
        totalCount++;
        if ({cout, busy, ec} !== e) begin
          $display("[TB] FAIL wrap_dir%0d_step%0d: got cout=%0d busy=%0b ec=%0b, want cout=%0d busy=%0b ec=%0b",
                   d, n, cout, busy, ec, e.cout, e.busy, e.ec);
        end else passCount++;
        if (expQ.size() != 0) tick();
      end
    end
  endtask

  task automatic test_error();
    wr_reg(3'd1, 8'd7);
    wr_reg(3'd0, 8'd9);
    start = 1'b1;
    tick();
    start = 1'b0;
    totalCount++;
    if ({cout, busy, ec, err} !== {8'd0, 3'b001}) begin
      $display("[TB] FAIL err_plr_above_ulr: got cout=%0d busy=%0b ec=%0b err=%0b, want cout=0 busy=0 ec=0 err=1",
               cout, busy, ec, err);
    end else passCount++;
    wr_reg(3'd0, 8'd6);
    start = 1'b1;
    tick();
    start = 1'b0;
    totalCount++;
    if ({cout, busy, err} !== {8'd6, 2'b10}) begin
      $display("[TB] FAIL err_recover: got cout=%0d busy=%0b err=%0b, want cout=6 busy=1 err=0",
               cout, busy, err);
    end else passCount++;
    wr_reg(3'd4, 8'd4);
    wr_reg(3'd3, 8'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    totalCount++;
    if ({cout, busy, err} !== {8'd0, 2'b01}) begin
      $display("[TB] FAIL err_ccr_zero: got cout=%0d busy=%0b err=%0b, want cout=0 busy=0 err=1",
               cout, busy, err);
    end else passCount++;
  endtask

  task automatic test_degenerate();
    exp_t e;
    wr_reg(3'd0, 8'd4);
    wr_reg(3'd2, 8'd4);
    wr_reg(3'd1, 8'd4);
    wr_reg(3'd3, 8'd3);
    wr_reg(3'd4, 8'd0);
    push_exp(8'd4, 1'b1, 1'b0);
    push_exp(8'd4, 1'b1, 1'b0);
    push_exp(8'd4, 1'b1, 1'b0);
    push_exp(8'd4, 1'b0, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; expQ.size() != 0; n++) begin
      e = expQ.pop_front();
      totalCount++;
      if ({cout, busy, ec, dir} !== {e, 1'b0}) begin
        $display("[TB] FAIL degen_step%0d: got cout=%0d busy=%0b ec=%0b dir=%0b, want cout=%0d busy=%0b ec=%0b dir=0",
                 n, cout, busy, ec, dir, e.cout, e.busy, e.ec);
      end else passCount++;
      if (expQ.size() != 0) tick();
    end
  endtask

  task automatic test_run_writes();
    logic [7:0] want;
    wr_reg(3'd0, 8'd5);
    wr_reg(3'd2, 8'd3);
    wr_reg(3'd1, 8'd7);
    wr_reg(3'd3, 8'd2);
    wr_reg(3'd4, 8'd2);
    // Start alongside a PLR write: the run must begin from the old PLR.
    bus.wr_en = 1'b1;
    bus.addr  = 3'd0;
    bus.wdata = 8'd6;
    start     = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    start     = 1'b0;
    totalCount++;
    if ({cout, busy} !== {8'd5, 1'b1}) begin
      $display("[TB] FAIL start_with_write: got cout=%0d busy=%0b, want cout=5 busy=1", cout, busy);
    end else passCount++;
    wr_reg(3'd0, 8'd1);
    bus.rd_en = 1'b1;
    bus.addr  = 3'd0;
    rdQ.push_back(8'd6);
    tick();
    bus.rd_en = 1'b0;
    want = rdQ.pop_front();
    totalCount++;
    if (bus.rdata !== want) begin
      $display("[TB] FAIL run_write_ignored: got PLR=%0d, want %0d", bus.rdata, want);
    end else passCount++;
    totalCount++;
    if (cout !== 8'd7) begin
      $display("[TB] FAIL run_progress: got cout=%0d, want 7", cout);
    end else passCount++;
    bus.wr_en = 1'b1;
    bus.addr  = 3'd4;
    bus.wdata = 8'd4;
    start     = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    start     = 1'b0;
    totalCount++;
    if ({cout, busy, ec} !== {8'd7, 2'b00}) begin
      $display("[TB] FAIL abort: got cout=%0d busy=%0b ec=%0b, want cout=7 busy=0 ec=0", cout, busy, ec);
    end else passCount++;
    bus.rd_en = 1'b1;
    bus.addr  = 3'd4;
    rdQ.push_back(8'd2);
    tick();
    bus.rd_en = 1'b0;
    want = rdQ.pop_front();
    totalCount++;
    if ({cout, busy, bus.rdata} !== {8'd7, 1'b0, want}) begin
      $display("[TB] FAIL abort_frozen_ctrl: got cout=%0d busy=%0b ctrl=%0d, want cout=7 busy=0 ctrl=%0d",
               cout, busy, bus.rdata, want);
    end else passCount++;
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] want;
    start = 1'b1;
    tick();
    start = 1'b0;
    totalCount++;
    if ({cout, busy} !== {8'd6, 1'b1}) begin
      $display("[TB] FAIL pre_reset_run: got cout=%0d busy=%0b, want cout=6 busy=1", cout, busy);
    end else passCount++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    totalCount++;
    if ({cout, busy, ec, dir} !== {8'd0, 3'b000}) begin
      $display("[TB] FAIL reset_mid_run: got cout=%0d busy=%0b ec=%0b dir=%0b, want all 0",
               cout, busy, ec, dir);
    end else passCount++;
    bus.rd_en = 1'b1;
    bus.addr  = 3'd1;
    rdQ.push_back(8'd255);
    tick();
    want = rdQ.pop_front();
    totalCount++;
    if (bus.rdata !== want) begin
      $display("[TB] FAIL reset_ulr: got %0d, want %0d", bus.rdata, want);
    end else passCount++;
    bus.addr = 3'd0;
    rdQ.push_back(8'd0);
    tick();
    bus.rd_en = 1'b0;
    want = rdQ.pop_front();
    totalCount++;
    if (bus.rdata !== want) begin
      $display("[TB] FAIL reset_plr: got %0d, want %0d", bus.rdata, want);
    end else passCount++;
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.addr  = 3'd0;
    bus.wdata = 8'd0;
    test_reset();
    test_bounce();
    test_wrap();
    test_error();
    test_degenerate();
    test_run_writes();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
